// File: rtl/dec_scan_ctrl.sv
// -----------------------------------------------------------------------------
// dec_scan_ctrl
//
// Scan sequencer for the lab_6 2-to-4 decoder. Walks the decoder outputs in the
// order 0 -> 1 -> 2 -> 3 -> 0. Each slot is driven for DIV cycles, or until a
// step request in single-step mode. A one-cycle blanking gap separates slots,
// so the select lines only ever change while the decoder is disabled.
//
// Parameters:
//   DIV         drive cycles per slot in free-run mode (1..255)
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       level: begin a scan at slot 0 (honoured only when idle)
//   stop        level: abort the scan and return to idle (overrides all else)
//   step_mode   1 = advance only on step, 0 = advance after DIV cycles
//   step        advance request, honoured only while driving in step mode
//   sel_a       decoder A input (select MSB)
//   sel_b       decoder B input (select LSB)
//   dec_en_n    decoder enable, active-low; low only while driving a slot
//   busy        high whenever the sequencer is not idle
//   frame_done  one-cycle pulse when slot 3 completes and the scan wraps to 0
// -----------------------------------------------------------------------------
module dec_scan_ctrl #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic stop,
  input  logic step_mode,
  input  logic step,
  output logic sel_a,
  output logic sel_b,
  output logic dec_en_n,
  output logic busy,
  output logic frame_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  // Terminal value of the drive counter for one free-run slot.
  localparam logic [7:0] cnt_last = 8'(DIV - 1);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic       fd_q, fd_d;
  logic       advance;

  // In step mode the counter is frozen and only step moves the scan on; in
  // free-run the counter reaching its terminal value does. Because cnt is
  // preserved across a step_mode change, switching back to free-run resumes
  // counting where it left off.
  assign advance = step_mode ? step : (cnt_q == cnt_last);

  // NOTE: every variable is given its hold/default value before the case
  // statement, so no path through this block leaves a signal unassigned and
  // no latch is inferred.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    fd_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = BLANK;
          idx_d   = 2'd0;
        end
      end

      BLANK: begin
        // Single blanking cycle; step is deliberately not looked at here.
        if (stop) begin
          state_d = IDLE;
        end else begin
          state_d = DRIVE;
          cnt_d   = 8'd0;
        end
      end

      DRIVE: begin
        // stop wins over a coincident advance: idx holds and no frame pulse.
        if (stop) begin
          state_d = IDLE;
        end else if (advance) begin
          state_d = BLANK;
          idx_d   = idx_q + 2'd1;
          fd_d    = (idx_q == 2'd3);
        end else if (!step_mode) begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= 8'd0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      fd_q    <= fd_d;
    end
  end

  // All outputs decode registered state only. The select lines change solely
  // on the edge that enters BLANK (or on reset), where the enable is already
  // high, which gives break-before-make for free.
  assign sel_a      = idx_q[1];
  assign sel_b      = idx_q[0];
  assign dec_en_n   = (state_q != DRIVE);
  assign busy       = (state_q != IDLE);
  assign frame_done = fd_q;

endmodule

// File: tb/tb_dec_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dec_scan_ctrl
//
// Two sequencer instances: one with DIV = 4 and one with DIV = 1. A behavioural
// model of each (slot number, cycles spent in the slot, blanking flag) runs
// alongside and every DUT output is compared with it on each falling edge,
// together with a break-before-make check. Directed sequences pin the model
// with hand-computed cycle-by-cycle expectations; a long random run follows.
// -----------------------------------------------------------------------------
module tb_dec_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic a_start = 0, a_stop = 0, a_step_mode = 0, a_step = 0;
  logic a_sel_a, a_sel_b, a_en_n, a_busy, a_fd;
  logic b_start = 0, b_stop = 0, b_step_mode = 0, b_step = 0;
  logic b_sel_a, b_sel_b, b_en_n, b_busy, b_fd;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dec_scan_ctrl #(.DIV(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .stop(a_stop),
    .step_mode(a_step_mode), .step(a_step), .sel_a(a_sel_a), .sel_b(a_sel_b),
    .dec_en_n(a_en_n), .busy(a_busy), .frame_done(a_fd)
  );

  dec_scan_ctrl #(.DIV(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .stop(b_stop),
    .step_mode(b_step_mode), .step(b_step), .sel_a(b_sel_a), .sel_b(b_sel_b),
    .dec_en_n(b_en_n), .busy(b_busy), .frame_done(b_fd)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: where the scan is, in plain integers.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit run;      // scanning at all
    bit gap;      // in the blanking gap before the current slot
    int slot;     // 0..3
    int held;     // drive cycles already spent in the current slot
    bit wrapped;  // a frame finished on the last edge
  } mdl_t;

  function automatic mdl_t mdl_next(mdl_t m, bit st, bit sp, bit smode, bit stp,
                                    int div);
    mdl_t n = m;
    bit   go;
    n.wrapped = 0;
    if (!m.run) begin
      if (st && !sp) begin
        n.run = 1; n.gap = 1; n.slot = 0;
      end
    end else if (sp) begin
      n.run = 0;
    end else if (m.gap) begin
      n.gap = 0; n.held = 0;
    end else begin
      go = smode ? stp : (m.held + 1 >= div);
      if (go) begin
        n.gap = 1;
        n.slot = (m.slot + 1) % 4;
        n.wrapped = (m.slot == 3);
      end else if (!smode) begin
        n.held = m.held + 1;
      end
    end
    return n;
  endfunction

  mdl_t ma, mb;
  localparam mdl_t mdl_rst = '{run: 0, gap: 0, slot: 0, held: 0, wrapped: 0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= mdl_rst;
      mb <= mdl_rst;
    end else begin
      ma <= mdl_next(ma, a_start, a_stop, a_step_mode, a_step, 4);
      mb <= mdl_next(mb, b_start, b_stop, b_step_mode, b_step, 1);
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare against the model, plus break-before-make.
  // ---------------------------------------------------------------------------
  int a_prev_sel = 0, b_prev_sel = 0;

  always @(negedge clk) begin
    int sa, sb;
    sa = {a_sel_a, a_sel_b};
    sb = {b_sel_a, b_sel_b};
    check("a_sel", sa, ma.slot);
    check("a_en_n", a_en_n, !(ma.run && !ma.gap));
    check("a_busy", a_busy, ma.run);
    check("a_frame_done", a_fd, ma.wrapped);
    check("b_sel", sb, mb.slot);
    check("b_en_n", b_en_n, !(mb.run && !mb.gap));
    check("b_busy", b_busy, mb.run);
    check("b_frame_done", b_fd, mb.wrapped);
    if (sa != a_prev_sel) check("a_bbm_en_n", a_en_n, 1);
    if (sb != b_prev_sel) check("b_bbm_en_n", b_en_n, 1);
    a_prev_sel = sa;
    b_prev_sel = sb;
  end

  // ---------------------------------------------------------------------------
  // Stimulus. Inputs change on falling edges; cycle c means the interval after
  // the c-th rising edge counted from the one that samples start.
  // ---------------------------------------------------------------------------
  initial begin
    #1;
    check("rst_a_sel", {a_sel_a, a_sel_b}, 0);
    check("rst_a_en_n", a_en_n, 1);
    check("rst_a_busy", a_busy, 0);
    check("rst_a_fd", a_fd, 0);
    check("rst_b_busy", b_busy, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);

    // Free-run, DIV = 4: slot period 5, frame period 20.
    a_start = 1;
    @(negedge clk);
    a_start = 0;
    for (int c = 1; c <= 41; c++) begin
      if (c == 1) begin
        check("fr_c1_busy", a_busy, 1);
        check("fr_c1_sel", {a_sel_a, a_sel_b}, 0);
        check("fr_c1_en_n", a_en_n, 1);
      end
      if (c >= 2 && c <= 5) begin
        check("fr_drive0_en_n", a_en_n, 0);
        check("fr_drive0_sel", {a_sel_a, a_sel_b}, 0);
      end
      if (c == 6) begin
        check("fr_c6_sel", {a_sel_a, a_sel_b}, 1);
        check("fr_c6_en_n", a_en_n, 1);
      end
      if (c == 21) check("fr_c21_sel", {a_sel_a, a_sel_b}, 0);
      check("fr_frame_done", a_fd, (c == 21 || c == 41) ? 1 : 0);
      if (c < 41) @(negedge clk);
    end
    a_stop = 1;
    @(negedge clk);
    a_stop = 0;
    check("fr_stopped_busy", a_busy, 0);

    // Stop together with the last drive cycle of slot 1 (cycle 10).
    a_start = 1;
    @(negedge clk);
    a_start = 0;
    repeat (9) @(negedge clk);
    check("stop_c10_sel", {a_sel_a, a_sel_b}, 1);
    check("stop_c10_en_n", a_en_n, 0);
    a_stop = 1;
    @(negedge clk);
    a_stop = 0;
    check("stop_c11_busy", a_busy, 0);
    check("stop_c11_sel", {a_sel_a, a_sel_b}, 1);
    check("stop_c11_en_n", a_en_n, 1);
    check("stop_c11_fd", a_fd, 0);

    // start and stop together while idle.
    a_start = 1;
    a_stop  = 1;
    @(negedge clk);
    a_start = 0;
    a_stop  = 0;
    check("startstop_busy", a_busy, 0);
    @(negedge clk);
    check("startstop_busy2", a_busy, 0);

    // Step mode: slot 0 is held, then one step advances exactly one slot even
    // though step stays high through the blanking cycle.
    a_step_mode = 1;
    a_start = 1;
    @(negedge clk);
    a_start = 0;
    for (int c = 2; c <= 52; c++) begin
      @(negedge clk);
      check("step_hold_en_n", a_en_n, 0);
      check("step_hold_sel", {a_sel_a, a_sel_b}, 0);
    end
    a_step = 1;
    @(negedge clk);
    check("step_blank_sel", {a_sel_a, a_sel_b}, 1);
    check("step_blank_en_n", a_en_n, 1);
    @(negedge clk);
    a_step = 0;
    check("step_drive_sel", {a_sel_a, a_sel_b}, 1);
    check("step_drive_en_n", a_en_n, 0);
    @(negedge clk);
    check("step_held_sel", {a_sel_a, a_sel_b}, 1);
    a_stop = 1;
    @(negedge clk);
    a_stop = 0;
    a_step_mode = 0;

    // Asynchronous reset while driving slot 2 (cycle 13).
    a_start = 1;
    @(negedge clk);
    a_start = 0;
    repeat (12) @(negedge clk);
    check("rst_mid_pre_sel", {a_sel_a, a_sel_b}, 2);
    check("rst_mid_pre_en_n", a_en_n, 0);
    #2 rst_n = 0;
    #1;
    check("rst_mid_sel", {a_sel_a, a_sel_b}, 0);
    check("rst_mid_en_n", a_en_n, 1);
    check("rst_mid_busy", a_busy, 0);
    check("rst_mid_fd", a_fd, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // DIV = 1: slot period 2, frame period 8; start while busy is ignored.
    b_start = 1;
    @(negedge clk);
    b_start = 0;
    for (int c = 1; c <= 24; c++) begin
      check("d1_sel", {b_sel_a, b_sel_b}, ((c - 1) / 2) % 4);
      check("d1_en_n", b_en_n, c % 2);
      check("d1_fd", b_fd, (c == 9 || c == 17) ? 1 : 0);
      b_start = (c == 20);
      if (c < 24) @(negedge clk);
    end
    b_start = 0;
    b_stop = 1;
    @(negedge clk);
    b_stop = 0;
    check("d1_stopped_busy", b_busy, 0);

    // Random run on both instances.
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      a_start = ($urandom_range(3) == 0);
      a_stop  = ($urandom_range(31) == 0);
      a_step  = ($urandom_range(7) == 0);
      if ($urandom_range(15) == 0) a_step_mode = ~a_step_mode;
      b_start = ($urandom_range(3) == 0);
      b_stop  = ($urandom_range(31) == 0);
      b_step  = ($urandom_range(3) == 0);
      if ($urandom_range(15) == 0) b_step_mode = ~b_step_mode;
    end
    @(negedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dec_scan_ctrl.md
# dec_scan_ctrl

Sequencer that drives the select and active-low enable inputs of the lab_6 2-to-4 decoder, scanning its four outputs in order 0→1→2→3→0. Sits directly upstream of the decoder. Each slot is held for a programmable number of cycles, and a one-cycle blanking gap separates slots so no two decoder outputs are ever active at once. Supports free-run and single-step modes and flags each completed frame.

## Interface
Parameters:
- `DIV`, default 4: drive cycles per slot; legal range 1..255.

Ports:
- `clk`, input, 1: sole clock; all state changes on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: level-sampled. In IDLE, begins a scan at slot 0.
- `stop`, input, 1: level-sampled. Aborts the scan and returns to IDLE.
- `step_mode`, input, 1: 1 = advance only on `step`; 0 = advance after `DIV` cycles.
- `step`, input, 1: advance request. Honoured only in DRIVE while `step_mode` = 1.
- `sel_a`, output, 1: decoder A input (select MSB).
- `sel_b`, output, 1: decoder B input (select LSB).
- `dec_en_n`, output, 1: decoder enable, active-low (0 = one decoder output active).
- `busy`, output, 1: 1 in any state other than IDLE.
- `frame_done`, output, 1: one-cycle pulse when slot 3 completes.

## Operation
- States: IDLE, BLANK, DRIVE. Encoding is free.
- Internal signals:
  - 2-bit slot index `idx`, with `{sel_a, sel_b}` = `idx`.
  - 8-bit drive counter `cnt`.
- Outputs by state:
  - `dec_en_n` = 0 only in DRIVE, otherwise 1.
  - `busy` = 0 only in IDLE.
- IDLE:
  - `start` = 1 and `stop` = 0 → BLANK; `idx` ← 0.
  - Otherwise stay; `idx` holds its last value.
- BLANK:
  - Lasts exactly 1 cycle, then → DRIVE with `cnt` ← 0.
  - `step` is ignored here.
- DRIVE, free-run (`step_mode` = 0):
  - `cnt` increments each cycle.
  - When `cnt` == `DIV`-1 → BLANK; `idx` ← `idx`+1, mod 4.
- DRIVE, step mode (`step_mode` = 1):
  - `cnt` is frozen; state is held indefinitely.
  - `step` = 1 → BLANK; `idx` ← `idx`+1, mod 4.
- `step_mode` changing mid-DRIVE:
  - Takes effect on the next edge.
  - 1→0 resumes counting from the frozen `cnt`.
- Wrap-around: `idx` 3→0 on advance is registered together with `frame_done` = 1 for that single cycle.
- `stop` = 1 in any non-IDLE state:
  - Next state is IDLE and `dec_en_n` = 1.
  - `idx` holds; no `frame_done`.
  - `stop` overrides a simultaneous advance or `step`.
- Simultaneous events:
  - `start` and `stop` together in IDLE → stay IDLE.
  - `start` while busy is ignored.
- Invariant: `dec_en_n` is never 0 in the same cycle that `sel_a`/`sel_b` change (break-before-make).

## Timing
- Reset, asynchronous on `rst_n` fall:
  - IDLE, `idx` = 0, `cnt` = 0.
  - Outputs: `sel_a` = 0, `sel_b` = 0, `dec_en_n` = 1, `busy` = 0, `frame_done` = 0.
- Reset mid-scan: outputs take reset values immediately, without waiting for a clock edge. Release is synchronous to the next `clk` edge.
- All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.
- Start latency:
  - `start` sampled at edge E → `busy` = 1 and `sel` = 00 after E.
  - First `dec_en_n` = 0 after edge E+1.
- Free-run slot period: `DIV`+1 cycles (1 BLANK + `DIV` DRIVE).
- Free-run frame period: 4·(`DIV`+1) cycles; `frame_done` spacing equals this.
- Step latency: `step` sampled in DRIVE at edge E → BLANK with new `sel` after E, DRIVE after E+1.
- Stop latency: `stop` sampled at edge E → `dec_en_n` = 1 and `busy` = 0 after E.

## Test plan
- Reset: assert `rst_n` = 0 mid-DRIVE with `idx` = 2 → immediately `sel` = 00, `dec_en_n` = 1, `busy` = 0, no clock required.
- Free-run, `DIV` = 4:
  - Pulse `start` at cycle 0.
  - `sel` = 00 in BLANK at cycle 1, `dec_en_n` = 0 for cycles 2–5.
  - `sel` = 01 in BLANK at cycle 6; `frame_done` high only at cycle 21 with `sel` = 00.
  - Second `frame_done` at cycle 41.
- Step mode:
  - With `step_mode` = 1 and `start`, DRIVE on slot 0 is held for 50 cycles.
  - `step` pulse → `sel` = 01 next cycle with `dec_en_n` = 1, then 0.
  - `step` during BLANK has no effect.
- Stop:
  - Assert `stop` together with the final DRIVE cycle of slot 1 → next cycle IDLE, `sel` = 01 held, `dec_en_n` = 1, no advance, no `frame_done`.
  - `start` + `stop` together in IDLE → stays IDLE.
- Break-before-make checker over a random run (`start`/`stop`/`step`/`step_mode` randomised, 10k cycles) → `sel` never changes while `dec_en_n` = 0; decoder one-hot output count ≤ 1 every cycle.
- `DIV` = 1: slot period 2 cycles and frame period 8 cycles; `start` while busy is ignored (`idx` is not reset).
